i2c_master_ctrl: RTL and testbench
==================================

# i2c_master_ctrl

Single-master I2C controller. Turns a level-sensitive start/stop/rw command with a 7-bit address and 8-bit write data into START, address+R/W, data and STOP bus sequences on SCL/SDA. Sits between a local command source (register block or FIFO front end) and the open-drain pad cells. SDA is split into an input and an output: output 1 means released, 0 means pulled low. The top level builds the open-drain pad from these.

## Interface
- CLK_DIV, default 1: system clocks per SCL quarter-period (≥1). SCL period = 4·CLK_DIV clocks.

- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level: request a transaction; sampled only in IDLE.
- stop  in  1  level: end the transaction after the current byte.
- rw  in  1  0 = write, 1 = read; latched with addr on acceptance.
- addr  in  7  target address; latched on acceptance.
- w_data  in  8  write byte; latched when each write byte begins.
- i2c_sda_i  in  1  sampled SDA bus level.
- i2c_scl  out  1  SCL drive (1 = released/high).
- i2c_sda_o  out  1  SDA drive (1 = released).
- r_data  out  8  last byte read.
- data_valid  out  1  one-clock pulse when r_data updates.
- ack_err  out  1  set on any NACK from the slave; cleared when the next transaction is accepted.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP.
- IDLE: SCL=1, SDA=1. If start=1, latch {addr,rw}, clear ack_err and enter START.
- START: SDA goes low while SCL is high. SCL then goes low.
- Bit cell of 4 quarters:
  - q0: SCL low; SDA is updated here only.
  - q1: SCL low.
  - q2: SCL high; i2c_sda_i is sampled on the last clock of q2.
  - q3: SCL high.
- Bits go MSB first.
- ADDR: shift {addr,rw} out as 8 bits. ADDR_ACK: release SDA and sample.
  - Sample = 1 (NACK): set ack_err and go to STOP.
  - Sample = 0 with rw=0: go to WRITE.
  - Sample = 0 with rw=1: go to READ.
- WRITE: latch w_data at q0 of bit 7 and shift it out. WRITE_ACK: release SDA and sample.
  - NACK: set ack_err and go to STOP.
  - ACK with stop=1: go to STOP.
  - ACK with stop=0: go to WRITE again and send a new w_data byte.
- READ: hold SDA released and shift in 8 sampled bits. After bit 0, update r_data and pulse data_valid.
- READ_ACK: drive SDA = stop (0 = ACK and continue, 1 = NACK). Then go to READ if stop=0, or STOP if stop=1.
- stop is sampled at q0 of the ACK slot (READ_ACK) or at the end of WRITE_ACK. At any other time it is ignored.
- STOP sequence, one quarter per step:
  - q0: SCL low, SDA low.
  - q1: SCL high, SDA low.
  - q2: SCL high, SDA high.
  - q3: lines held released.
  - Then go to IDLE.
- IDLE lasts at least one clock before a new start is accepted. If start is held high, back-to-back transactions follow.
- Changes to addr, rw or start during a transaction have no effect.

## Timing
- Reset values: i2c_scl=1, i2c_sda_o=1, r_data=0, data_valid=0, ack_err=0, busy=0, state=IDLE.
- Reset asserted mid-transfer releases both lines on the next clock edge. No STOP is generated.
- Quarter counter runs 0..CLK_DIV-1. State and bit advance happen when the counter wraps.
- Acceptance: busy rises on the clock after start is seen in IDLE.
- The START condition takes 4 quarters.
- SDA may change only while SCL is low, except the START and STOP edges.
- Single-byte write, ACKed: 4 + 36 + 36 + 4 = 80 quarters from START to IDLE. busy is high for exactly 80·CLK_DIV clocks.
- Address NACK: 4 + 36 + 4 = 44 quarters.
- data_valid is asserted on the clock that r_data is written.

## Test plan
- Reset: hold reset 1 for 2 clocks, then check scl=1, sda_o=1, busy=0, ack_err=0. Assert reset mid-ADDR and check both lines are released on the next clock.
- Loopback (sda_i tied to sda_o), CLK_DIV=1: start=1, rw=0, addr=0x55, w_data=0xAA.
  - START, then bits 1010101 followed by 0.
  - Released ACK slot reads 1, so ack_err=1.
  - STOP follows; busy lasts 44 clocks.
- ACKing slave model, CLK_DIV=2: write addr=0x55, w_data=0xAA, stop=1.
  - Bus shows START, 0xAA, ACK, 0xAA, ACK, STOP.
  - ack_err=0; busy lasts 160 clocks.
- Slave returns 0x01 and 0xD3, rw=1, stop=0 through the first byte, then stop=1.
  - Master ACKs 0x01 and NACKs 0xD3.
  - data_valid pulses twice; r_data ends at 0xD3.
- Multi-byte write with stop=0: change w_data to 0x3C after the first byte. The second byte on the bus is 0x3C.
- Slave NACKs a data byte: ack_err=1 and STOP follows immediately. With start held high, the next transaction begins after IDLE and ack_err clears.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: turns a level-sensitive start/stop/rw command into
// START, address+R/W, data and STOP sequences on split open-drain SCL/SDA lines.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] w_data,
    input  logic       i2c_sda_i,
    output logic       i2c_scl,
    output logic       i2c_sda_o,
    output logic [7:0] r_data,
    output logic       data_valid,
    output logic       ack_err,
    output logic       busy
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
        S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
    } state_t;

    state_t        state_reg, state_next;
    logic [QW-1:0] qcnt_reg;
    logic [1:0]    quarter_reg;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg;
    logic [7:0]    r_data_reg;
    logic          rw_reg;
    logic          sample_reg;
    logic          stop_reg;
    logic          data_valid_reg;
    logic          ack_err_reg;
    logic          q_wrap;
    logic          sample_now;
    logic          cell_end;
    logic          in_data;

    assign q_wrap     = (qcnt_reg == Q_LAST);
    assign sample_now = q_wrap && (quarter_reg == 2'd2);
    assign cell_end   = q_wrap && (quarter_reg == 2'd3);
    assign in_data    = (state_reg == S_ADDR) || (state_reg == S_WRITE) || (state_reg == S_READ);

    assign r_data     = r_data_reg;
    assign data_valid = data_valid_reg;
    assign ack_err    = ack_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (start) state_next = S_START;
            S_START:     if (cell_end) state_next = S_ADDR;
            S_ADDR:      if (cell_end && bit_reg == 3'd0) state_next = S_ADDR_ACK;
            S_ADDR_ACK:  if (cell_end) state_next = sample_reg ? S_STOP : (rw_reg ? S_READ : S_WRITE);
            S_WRITE:     if (cell_end && bit_reg == 3'd0) state_next = S_WRITE_ACK;
            S_WRITE_ACK: if (cell_end) state_next = (sample_reg || stop) ? S_STOP : S_WRITE;
            S_READ:      if (cell_end && bit_reg == 3'd0) state_next = S_READ_ACK;
            S_READ_ACK:  if (cell_end) state_next = stop_reg ? S_STOP : S_READ;
            S_STOP:      if (cell_end) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qcnt_reg       <= '0;
            quarter_reg    <= 2'd0;
            bit_reg        <= 3'd7;
            shift_reg      <= 8'h00;
            r_data_reg     <= 8'h00;
            rw_reg         <= 1'b0;
            sample_reg     <= 1'b1;
            stop_reg       <= 1'b0;
            data_valid_reg <= 1'b0;
            ack_err_reg    <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            if (state_reg == S_IDLE) begin
                qcnt_reg    <= '0;
                quarter_reg <= 2'd0;
                bit_reg     <= 3'd7;
                if (start) begin
                    shift_reg   <= {addr, rw};
                    rw_reg      <= rw;
                    ack_err_reg <= 1'b0;
                end
            end else begin
                qcnt_reg <= q_wrap ? '0 : qcnt_reg + 1'b1;
                if (q_wrap) quarter_reg <= quarter_reg + 2'd1;
                if (sample_now) begin
                    sample_reg <= i2c_sda_i;
                    if (state_reg == S_READ) shift_reg <= {shift_reg[6:0], i2c_sda_i};
                end
                if (cell_end) begin
                    // Non-data states last exactly one bit cell, so re-arming here starts every byte at bit 7
                    bit_reg <= in_data ? bit_reg - 3'd1 : 3'd7;
                    if (state_reg == S_ADDR || state_reg == S_WRITE)
                        shift_reg <= {shift_reg[6:0], 1'b0};
                    if (state_next == S_WRITE && state_reg != S_WRITE)
                        shift_reg <= w_data;
                    if (state_next == S_READ_ACK) begin
                        r_data_reg     <= shift_reg;
                        data_valid_reg <= 1'b1;
                        stop_reg       <= stop;
                    end
                    if ((state_reg == S_ADDR_ACK || state_reg == S_WRITE_ACK) && sample_reg)
                        ack_err_reg <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        i2c_scl   = 1'b1;
        i2c_sda_o = 1'b1;
        busy      = (state_reg != S_IDLE);
        case (state_reg)
            S_START: begin
                i2c_sda_o = 1'b0;
                i2c_scl   = ~quarter_reg[1];
            end
            S_ADDR, S_WRITE: begin
                i2c_scl   = quarter_reg[1];
                i2c_sda_o = shift_reg[7];
            end
            S_ADDR_ACK, S_WRITE_ACK, S_READ: begin
                i2c_scl = quarter_reg[1];
            end
            S_READ_ACK: begin
                i2c_scl   = quarter_reg[1];
                i2c_sda_o = stop_reg;
            end
            S_STOP: begin
                // SDA rises while SCL is high to form the STOP condition
                i2c_scl   = (quarter_reg != 2'd0);
                i2c_sda_o = quarter_reg[1];
            end
            default: begin
                i2c_scl   = 1'b1;
                i2c_sda_o = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: a loopback instance at CLK_DIV=1 and a
// CLK_DIV=2 instance on a small behavioural I2C slave, both seen by one bus monitor.
module tb_i2c_master_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, start1 = 1'b0, start2 = 1'b0, stop = 1'b0, rw = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] w_data = 8'h00;
    logic       scl1, sda1, dv1, err1, busy1;
    logic       scl2, sda2, dv2, err2, busy2;
    logic [7:0] rd1, rd2;
    logic       slave_sda = 1'b1, slave_en = 1'b0, sel = 1'b0;
    logic       sda2_i;

    assign sda2_i = sda2 & slave_sda;

    i2c_master_ctrl #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .stop(stop), .rw(rw), .addr(addr),
        .w_data(w_data), .i2c_sda_i(sda1), .i2c_scl(scl1), .i2c_sda_o(sda1),
        .r_data(rd1), .data_valid(dv1), .ack_err(err1), .busy(busy1)
    );

    i2c_master_ctrl #(.CLK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .stop(stop), .rw(rw), .addr(addr),
        .w_data(w_data), .i2c_sda_i(sda2_i), .i2c_scl(scl2), .i2c_sda_o(sda2),
        .r_data(rd2), .data_valid(dv2), .ack_err(err2), .busy(busy2)
    );

    int         errors = 0, checks = 0;
    logic [7:0] bytes_q[$];
    logic       acks_q[$];
    logic [7:0] rd_log[$];
    int         starts = 0, stops = 0, busy_cnt = 0, dv_cnt = 0, nack_frame = -1;
    logic [7:0] rbytes [4] = '{8'h01, 8'hD3, 8'h00, 8'h00};
    logic       prev_scl = 1'b1, prev_sda = 1'b1, rd_mode = 1'b0;
    logic [7:0] sh = 8'h00;
    int         bitn = 0, fidx = 0, ridx = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        bytes_q.delete();
        acks_q.delete();
        rd_log.delete();
        starts = 0; stops = 0; busy_cnt = 0; dv_cnt = 0;
    endtask

    function automatic logic [7:0] byte_at(input int i);
        return (bytes_q.size() > i) ? bytes_q[i] : 8'hxx;
    endfunction

    function automatic logic ack_at(input int i);
        return (acks_q.size() > i) ? acks_q[i] : 1'bx;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((sel ? busy2 : busy1) && n <= budget) begin
            tick(1);
            n++;
        end
        if (n > budget) check({tag, " idle timeout"}, 0, 1);
    endtask

    task automatic wait_bytes(input string tag, input int cnt, input int budget);
        int n = 0;
        while (bytes_q.size() < cnt && n <= budget) begin
            tick(1);
            n++;
        end
        if (n > budget) check({tag, " byte timeout"}, 0, 1);
    endtask

    task automatic wait_dv(input string tag, input int cnt, input int budget);
        int n = 0;
        while (dv_cnt < cnt && n <= budget) begin
            tick(1);
            n++;
        end
        if (n > budget) check({tag, " data_valid timeout"}, 0, 1);
    endtask

    // Bus monitor and slave: decodes START/STOP, captures bits on SCL rise, drives on SCL fall
    initial begin : monitor
        logic c, b;
        forever begin
            @(negedge clk);
            c = sel ? scl2 : scl1;
            b = sel ? sda2_i : sda1;
            if (sel ? busy2 : busy1) busy_cnt++;
            if (sel ? dv2 : dv1) begin
                dv_cnt++;
                rd_log.push_back(sel ? rd2 : rd1);
            end
            if (prev_scl && c && prev_sda && !b) begin
                starts++;
                bitn = 0; fidx = 0; ridx = 0; rd_mode = 1'b0; slave_sda = 1'b1;
            end else if (prev_scl && c && !prev_sda && b) begin
                stops++;
                slave_sda = 1'b1;
            end else if (!prev_scl && c) begin
                if (bitn < 8) sh = {sh[6:0], b};
                else acks_q.push_back(b);
                bitn++;
            end else if (prev_scl && !c) begin
                if (bitn == 8) begin
                    bytes_q.push_back(sh);
                    if (fidx == 0 || !rd_mode) begin
                        slave_sda = (!slave_en || fidx == nack_frame);
                    end else begin
                        slave_sda = 1'b1;
                        ridx++;
                    end
                end else if (bitn == 9) begin
                    bitn = 0;
                    if (fidx == 0) rd_mode = sh[0];
                    fidx++;
                    if (slave_en && rd_mode && acks_q[$] == 1'b0 && ridx < 4)
                        slave_sda = rbytes[ridx][7];
                    else
                        slave_sda = 1'b1;
                end else if (bitn >= 1 && bitn <= 7 && slave_en && rd_mode && fidx > 0 && ridx < 4) begin
                    slave_sda = rbytes[ridx][7 - bitn];
                end
            end
            prev_scl = c;
            prev_sda = b;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst scl1", scl1, 1);
        check("rst sda1", sda1, 1);
        check("rst busy1", busy1, 0);
        check("rst ack_err1", err1, 0);
        check("rst r_data1", rd1, 0);
        check("rst data_valid1", dv1, 0);
        check("rst scl2", scl2, 1);
        check("rst busy2", busy2, 0);
        reset = 1'b0;
        tick(1);

        // Loopback write: the released ACK slot reads back 1
        clear_mon();
        addr = 7'h55; rw = 1'b0; w_data = 8'hAA; stop = 1'b0;
        start1 = 1'b1; tick(1); start1 = 1'b0;
        wait_idle("lb", 100);
        check("lb busy clocks", busy_cnt, 44);
        check("lb starts", starts, 1);
        check("lb stops", stops, 1);
        check("lb byte count", bytes_q.size(), 1);
        check("lb addr byte", byte_at(0), 8'hAA);
        check("lb ack slot", ack_at(0), 1);
        check("lb ack_err", err1, 1);
        $display("txn loopback addr=55 w: bytes=%0d busy=%0d ack_err=%0d", bytes_q.size(), busy_cnt, err1);

        // Reset in the middle of ADDR while SCL and SDA are both low
        tick(1);
        start1 = 1'b1; tick(1); start1 = 1'b0;
        check("accept clears ack_err", err1, 0);
        tick(8);
        check("mid addr scl", scl1, 0);
        check("mid addr sda", sda1, 0);
        check("mid addr busy", busy1, 1);
        reset = 1'b1; tick(1);
        check("rst mid scl", scl1, 1);
        check("rst mid sda", sda1, 1);
        check("rst mid busy", busy1, 0);
        reset = 1'b0; tick(2);
        $display("txn reset mid-ADDR: scl=%0d sda=%0d busy=%0d", scl1, sda1, busy1);

        // Single-byte write to an ACKing slave at CLK_DIV=2
        sel = 1'b1; slave_en = 1'b1; nack_frame = -1;
        tick(2);
        clear_mon();
        addr = 7'h55; rw = 1'b0; w_data = 8'hAA; stop = 1'b1;
        start2 = 1'b1; tick(1); start2 = 1'b0;
        wait_idle("wr", 400);
        check("wr busy clocks", busy_cnt, 160);
        check("wr starts", starts, 1);
        check("wr stops", stops, 1);
        check("wr byte count", bytes_q.size(), 2);
        check("wr addr byte", byte_at(0), 8'hAA);
        check("wr data byte", byte_at(1), 8'hAA);
        check("wr addr ack", ack_at(0), 0);
        check("wr data ack", ack_at(1), 0);
        check("wr ack_err", err2, 0);
        $display("txn write addr=55 data=AA: busy=%0d ack_err=%0d", busy_cnt, err2);

        // Two-byte read: master ACKs 0x01, NACKs 0xD3
        tick(2);
        clear_mon();
        addr = 7'h2A; rw = 1'b1; stop = 1'b0;
        start2 = 1'b1; tick(1); start2 = 1'b0;
        wait_dv("rd", 1, 400);
        stop = 1'b1;
        wait_idle("rd", 600);
        check("rd busy clocks", busy_cnt, 232);
        check("rd data_valid pulses", dv_cnt, 2);
        check("rd first r_data", (rd_log.size() > 0) ? rd_log[0] : 8'hxx, 8'h01);
        check("rd final r_data", rd2, 8'hD3);
        check("rd addr byte", byte_at(0), 8'h55);
        check("rd bus byte0", byte_at(1), 8'h01);
        check("rd bus byte1", byte_at(2), 8'hD3);
        check("rd slave addr ack", ack_at(0), 0);
        check("rd master ack", ack_at(1), 0);
        check("rd master nack", ack_at(2), 1);
        check("rd stops", stops, 1);
        check("rd ack_err", err2, 0);
        $display("txn read addr=2A: bytes=%0d valid=%0d r_data=%02h", bytes_q.size(), dv_cnt, rd2);

        // Two-byte write, w_data changed while the first byte is on the bus
        tick(2);
        clear_mon();
        addr = 7'h55; rw = 1'b0; w_data = 8'hAA; stop = 1'b0;
        start2 = 1'b1; tick(1); start2 = 1'b0;
        wait_bytes("mw", 2, 400);
        w_data = 8'h3C;
        wait_bytes("mw", 3, 400);
        stop = 1'b1;
        wait_idle("mw", 400);
        check("mw byte count", bytes_q.size(), 3);
        check("mw first data", byte_at(1), 8'hAA);
        check("mw second data", byte_at(2), 8'h3C);
        check("mw stops", stops, 1);
        check("mw ack_err", err2, 0);
        $display("txn multi-write: bytes=%0d busy=%0d", bytes_q.size(), busy_cnt);

        // Data-byte NACK with start held: STOP at once, then a fresh transaction
        tick(2);
        clear_mon();
        nack_frame = 1; stop = 1'b0; w_data = 8'h5A;
        start2 = 1'b1; tick(1);
        wait_idle("nk", 400);
        check("nk busy clocks", busy_cnt, 160);
        check("nk data ack", ack_at(1), 1);
        check("nk stops", stops, 1);
        check("nk ack_err", err2, 1);
        $display("txn write nack: busy=%0d ack_err=%0d", busy_cnt, err2);
        clear_mon();
        nack_frame = -1; stop = 1'b1;
        tick(1);
        start2 = 1'b0;
        check("b2b busy", busy2, 1);
        check("b2b ack_err cleared", err2, 0);
        wait_idle("b2b", 400);
        check("b2b busy clocks", busy_cnt, 160);
        check("b2b starts", starts, 1);
        check("b2b data byte", byte_at(1), 8'h5A);
        check("b2b data ack", ack_at(1), 0);
        check("b2b ack_err", err2, 0);
        $display("txn back-to-back write: busy=%0d ack_err=%0d", busy_cnt, err2);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
